// File: rtl/sme_pkg.sv
// Shared constants and state encoding for the string-match engine.
package sme_pkg;

    localparam logic [7:0] CH_HAT    = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_STR,
        LOAD_PAT,
        SCAN,
        REPORT
    } state_t;

endpackage

// File: rtl/sme_char_cmp.sv
// Combinational compare of one pattern symbol against the string at the current
// scan position; classifies zero-width anchors and reports whether they hold.
module sme_char_cmp
    import sme_pkg::*;
#(
    parameter int CHAR_W = 8
) (
    input  logic [CHAR_W-1:0] pat_ch,
    input  logic [CHAR_W-1:0] str_ch,
    input  logic [CHAR_W-1:0] prev_ch,
    input  logic              is_first,
    input  logic              is_last,
    input  logic              at_start,
    input  logic              in_range,
    input  logic              at_end,
    output logic              is_anchor,
    output logic              anchor_ok,
    output logic              hit
);
    logic is_hat;
    logic is_dollar;

    always_comb begin
        is_hat    = is_first && (pat_ch == CHAR_W'(CH_HAT));
        is_dollar = is_last && (pat_ch == CHAR_W'(CH_DOLLAR));
        is_anchor = is_hat || is_dollar;
        // '^' looks one char back, '$' looks at the char the body would consume next
        anchor_ok = is_hat ? (at_start || (prev_ch == CHAR_W'(CH_SPACE)))
                           : (at_end || (in_range && (str_ch == CHAR_W'(CH_SPACE))));
        hit       = in_range && ((pat_ch == CHAR_W'(CH_DOT)) || (pat_ch == str_ch));
    end

endmodule

// File: rtl/sme_param_matcher.sv
// Serial-load string matcher: '^', '$', '.' symbols, plus '*' when SME_STAR_EN is defined.
// One valid pulse per pattern reports match and the leftmost start index.
module sme_param_matcher
    import sme_pkg::*;
#(
    parameter int  CHAR_W  = 8,
    parameter int  STR_MAX = 32,
    parameter int  PAT_MAX = 8,
    localparam int IDX_W   = $clog2(STR_MAX)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] chardata,
    input  logic              isstring,
    input  logic              ispattern,
    output logic              busy,
    output logic              valid,
    output logic              match,
    output logic [IDX_W-1:0]  match_index
);
    localparam int LEN_W  = $clog2(STR_MAX + 1);
    localparam int PLEN_W = $clog2(PAT_MAX + 1);
    localparam int PIDX_W = $clog2(PAT_MAX);
    localparam int POS_W  = $clog2(STR_MAX + PAT_MAX + 1);

    state_t            state_reg, state_next;
    logic [CHAR_W-1:0] str_mem [STR_MAX];
    logic [CHAR_W-1:0] pat_mem [PAT_MAX];
    logic [LEN_W-1:0]  slen_reg;
    logic [PLEN_W-1:0] plen_reg;
    logic              str_run_reg;
    logic [POS_W-1:0]  s_reg, k_reg;
    logic [PLEN_W-1:0] p_reg;
    logic              match_reg;
    logic [IDX_W-1:0]  match_index_reg;

    logic              loading, str_we, pat_we;
    logic [IDX_W-1:0]  str_waddr;
    logic [PIDX_W-1:0] pat_waddr;

    always_comb begin
        loading   = (state_reg == IDLE) || (state_reg == LOAD_STR) || (state_reg == LOAD_PAT);
        str_we    = 1'b0;
        pat_we    = 1'b0;
        str_waddr = '0;
        pat_waddr = '0;
        if (loading && isstring) begin
            str_we    = !str_run_reg || (slen_reg < LEN_W'(STR_MAX));
            str_waddr = str_run_reg ? slen_reg[IDX_W-1:0] : '0;
        end else if (loading && ispattern) begin
            pat_we    = (state_reg != LOAD_PAT) || (plen_reg < PLEN_W'(PAT_MAX));
            pat_waddr = (state_reg == LOAD_PAT) ? plen_reg[PIDX_W-1:0] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slen_reg    <= '0;
            plen_reg    <= '0;
            str_run_reg <= 1'b0;
        end else begin
            str_run_reg <= loading && isstring;
            if (str_we)
                slen_reg <= str_run_reg ? slen_reg + LEN_W'(1) : LEN_W'(1);
            if (pat_we)
                plen_reg <= (state_reg == LOAD_PAT) ? plen_reg + PLEN_W'(1) : PLEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (str_we)
            str_mem[str_waddr] <= chardata;
        if (pat_we)
            pat_mem[pat_waddr] <= chardata;
    end

    // Scan datapath: string position is segment base + consumed-char offset k
    logic [POS_W-1:0]  cur_base, pos;
    logic [IDX_W-1:0]  prev_idx;
    logic [CHAR_W-1:0] pat_ch, str_ch, prev_ch;
    logic              in_range, at_end, is_anchor, anchor_ok, hit;
    logic              pat_done, is_star, step_ok, scan_fail, scan_end;
    logic              in_suffix, suffix_exhausted;
    logic [PLEN_W-1:0] retry_p;

`ifdef SME_STAR_EN
    logic [POS_W-1:0]  t_reg;
    logic              in_suffix_reg;
    logic [PLEN_W-1:0] star_p_reg;

    assign in_suffix        = in_suffix_reg;
    assign retry_p          = star_p_reg;
    assign suffix_exhausted = t_reg >= POS_W'(slen_reg);
    assign cur_base         = in_suffix_reg ? t_reg : s_reg;
    assign is_star          = !in_suffix_reg && (pat_ch == CHAR_W'(CH_STAR));
`else
    assign in_suffix        = 1'b0;
    assign retry_p          = '0;
    assign suffix_exhausted = 1'b0;
    assign cur_base         = s_reg;
    assign is_star          = 1'b0;
`endif

    assign pos      = cur_base + k_reg;
    assign in_range = pos < POS_W'(slen_reg);
    assign at_end   = pos == POS_W'(slen_reg);
    assign prev_idx = s_reg[IDX_W-1:0] - IDX_W'(1);
    assign pat_ch   = pat_mem[p_reg[PIDX_W-1:0]];
    assign str_ch   = str_mem[pos[IDX_W-1:0]];
    assign prev_ch  = str_mem[prev_idx];

    sme_char_cmp #(.CHAR_W(CHAR_W)) u_cmp (
        .pat_ch    (pat_ch),
        .str_ch    (str_ch),
        .prev_ch   (prev_ch),
        .is_first  (p_reg == '0),
        .is_last   (p_reg == plen_reg - PLEN_W'(1)),
        .at_start  (s_reg == '0),
        .in_range  (in_range),
        .at_end    (at_end),
        .is_anchor (is_anchor),
        .anchor_ok (anchor_ok),
        .hit       (hit)
    );

    always_comb begin
        pat_done  = p_reg == plen_reg;
        step_ok   = is_anchor ? anchor_ok : hit;
        scan_fail = !pat_done && !is_star && !step_ok &&
                    (in_suffix ? suffix_exhausted
                               : (s_reg + POS_W'(1) >= POS_W'(slen_reg)));
        scan_end  = (state_reg == SCAN) && (pat_done || scan_fail);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_reg           <= '0;
            k_reg           <= '0;
            p_reg           <= '0;
            match_reg       <= 1'b0;
            match_index_reg <= '0;
        end else if (state_reg != SCAN) begin
            s_reg <= '0;
            k_reg <= '0;
            p_reg <= '0;
        end else if (pat_done) begin
            match_reg       <= 1'b1;
            match_index_reg <= s_reg[IDX_W-1:0];
        end else if (is_star) begin
            p_reg <= p_reg + PLEN_W'(1);
            k_reg <= '0;
        end else if (step_ok) begin
            p_reg <= p_reg + PLEN_W'(1);
            if (!is_anchor)
                k_reg <= k_reg + POS_W'(1);
        end else if (scan_fail) begin
            match_reg       <= 1'b0;
            match_index_reg <= '0;
        end else begin
            p_reg <= retry_p;
            k_reg <= '0;
            if (!in_suffix)
                s_reg <= s_reg + POS_W'(1);
        end
    end

`ifdef SME_STAR_EN
    // A failed suffix slides its own base; a later start could only see a later suffix base
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_reg         <= '0;
            in_suffix_reg <= 1'b0;
            star_p_reg    <= '0;
        end else if (state_reg != SCAN) begin
            in_suffix_reg <= 1'b0;
        end else if (!pat_done && is_star) begin
            in_suffix_reg <= 1'b1;
            t_reg         <= pos;
            star_p_reg    <= p_reg + PLEN_W'(1);
        end else if (!pat_done && !step_ok && !scan_fail && in_suffix_reg) begin
            t_reg <= t_reg + POS_W'(1);
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (isstring) state_next = LOAD_STR;
                      else if (ispattern) state_next = LOAD_PAT;
            LOAD_STR: if (!isstring && ispattern) state_next = LOAD_PAT;
            LOAD_PAT: if (isstring) state_next = LOAD_STR;
                      else if (!ispattern) state_next = SCAN;
            SCAN:     if (scan_end) state_next = REPORT;
            REPORT:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    assign busy        = (state_reg == SCAN) || (state_reg == REPORT);
    assign valid       = state_reg == REPORT;
    assign match       = match_reg;
    assign match_index = match_index_reg;

endmodule
